dm_store_buffer: RTL and testbench

Store write buffer between the M-stage store path and the data memory DM. It aligns SW/SH/SB stores to a word address, replicated data and a 4-bit byte enable, and queues them in a DEPTH-entry FIFO. Entries drain to DM one per cycle while `dm_ready` is high. Loads whose word address matches a pending store are stalled until that store has drained, so DM reads never return stale data.

---
 rtl/dm_store_buffer_if.sv | 29 ++
 rtl/dm_store_buffer.sv | 152 +++++++++++++++
 tb/tb_dm_store_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_store_buffer_if.sv
// Store/load request and DM write-port bundle for dm_store_buffer.
// master = M-stage / DM side, slave = the store buffer.
interface dm_store_buffer_if;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [31:0] st_pc;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        dm_ready;
   logic        st_stall;
   logic        ld_stall;
   logic        misalign;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_inst_addr;

   modport master (
      output st_valid, st_op, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_ready,
      input  st_stall, ld_stall, misalign, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr
   );

   modport slave (
      input  st_valid, st_op, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_ready,
      output st_stall, ld_stall, misalign, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr
   );
endinterface

// File: rtl/dm_store_buffer.sv
// Store write buffer: aligns SW/SH/SB stores, queues them in a DEPTH-entry FIFO and drains to DM.
// Optional feature: define DM_STORE_BYPASS_EN to write straight through when the FIFO is empty.
module dm_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 Reset,
   dm_store_buffer_if.slave     bus,
   output logic [CNT_W-1:0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  byteen;
      logic [31:0] pc;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   cnt_q;

   logic [3:0]  al_byteen;
   logic [31:0] al_data;
   logic        al_mis;
   entry_t      st_entry;
   entry_t      wr_sel;
   logic        st_req;
   logic        st_ok;
   logic        full;
   logic        push;
   logic        pop;
   logic        bypass;
   logic        ld_hit;
   logic        unused_ld_lsb;

   assign unused_ld_lsb = ^bus.ld_addr[1:0];

   // Lane alignment and misalignment detection for the incoming store
   always_comb begin
      al_byteen = 4'b0000;
      al_data   = 32'h0;
      al_mis    = 1'b0;
      case (bus.st_op)
         2'b11: begin
            al_byteen = 4'b1111;
            al_data   = bus.st_data;
            al_mis    = |bus.st_addr[1:0];
         end
         2'b10: begin
            al_byteen = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            al_data   = {2{bus.st_data[15:0]}};
            al_mis    = bus.st_addr[0];
         end
         2'b01: begin
            al_byteen = 4'b0001 << bus.st_addr[1:0];
            al_data   = {4{bus.st_data[7:0]}};
         end
         default: begin
            al_byteen = 4'b0000;
         end
      endcase
   end

   assign st_entry.addr   = {bus.st_addr[31:2], 2'b00};
   assign st_entry.data   = al_data;
   assign st_entry.byteen = al_byteen;
   assign st_entry.pc     = bus.st_pc;

   assign st_req = bus.st_valid & (bus.st_op != 2'b00);
   assign st_ok  = st_req & ~al_mis;
   assign full   = (cnt_q == CNT_W'(DEPTH));

`ifdef DM_STORE_BYPASS_EN
   assign bypass = st_ok & (cnt_q == '0) & bus.dm_ready & ~Reset;
`else
   assign bypass = 1'b0;
`endif

   assign pop  = (cnt_q != '0) & bus.dm_ready & ~Reset;
   assign push = st_ok & ~full & ~bypass & ~Reset;

   assign bus.misalign = st_req & al_mis;
   assign bus.st_stall = st_ok & full;

   // Word-address match against every occupied slot, head included
   always_comb begin
      logic [PTR_W-1:0] rel;
      ld_hit = 1'b0;
      rel    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         rel = PTR_W'(i) - rd_ptr;
         if ((CNT_W'(rel) < cnt_q) && (mem[i].addr[31:2] == bus.ld_addr[31:2])) begin
            ld_hit = 1'b1;
         end
      end
   end

   assign bus.ld_stall = bus.ld_valid & ld_hit;

   // DM write port: FIFO head, else the bypassed store, else idle zeros
   always_comb begin
      wr_sel = '0;
      if (pop) begin
         wr_sel = mem[rd_ptr];
      end else if (bypass) begin
         wr_sel = st_entry;
      end
   end

   assign bus.m_data_addr   = wr_sel.addr;
   assign bus.m_data_wdata  = wr_sel.data;
   assign bus.m_data_byteen = wr_sel.byteen;
   assign bus.m_inst_addr   = wr_sel.pc;

   assign count = Reset ? '0 : cnt_q;

   // Pointer and occupancy state
   always_ff @(posedge clk) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Payload storage; contents are only meaningful while counted as occupied
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= st_entry;
      end
   end

   a_cnt_bound : assert property (@(posedge clk) disable iff (Reset) cnt_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: directed scenarios then random traffic vs. a queue model.
module tb_dm_store_buffer;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             Reset;
   logic [CNT_W-1:0] count;

   dm_store_buffer_if sb_if ();

   dm_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (sb_if),
      .count (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] pc;
   } wr_t;

   wr_t pend [$];
   wr_t exp_q [$];
   wr_t mw;

   int  total = 0;
   int  bad   = 0;
   bit  chk_en = 1'b0;
   int  e_cnt;
   bit  e_mis, e_sst, e_lst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   function automatic bit is_mis(input logic [1:0] op, input logic [31:0] a);
      if (op == 2'b11) return (a % 4) != 0;
      if (op == 2'b10) return (a % 2) != 0;
      return 1'b0;
   endfunction

   function automatic wr_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] pc);
      wr_t w;
      w.addr = a - (a % 4);
      w.pc   = pc;
      if (op == 2'b11) begin
         w.be = 4'hF; w.data = d;
      end else if (op == 2'b10) begin
         w.be = 4'(3 << (a & 2)); w.data = (d & 32'hFFFF) * 32'h0001_0001;
      end else begin
         w.be = 4'(1 << (a % 4)); w.data = (d & 32'hFF) * 32'h0101_0101;
      end
      return w;
   endfunction

   function automatic bit ld_hit(input logic [31:0] la);
      foreach (pend[i]) if ((pend[i].addr / 4) == (la / 4)) return 1'b1;
      return 1'b0;
   endfunction

   // One cycle: drive inputs, predict outputs, advance the model, cross the edge
   task automatic step(input logic sv, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic lv, input logic [31:0] la,
                       input logic rdy, input logic rst);
      bit req, mis, ok, full, wr_now, byp;
      sb_if.st_valid = sv; sb_if.st_op = op; sb_if.st_addr = a; sb_if.st_data = d; sb_if.st_pc = pc;
      sb_if.ld_valid = lv; sb_if.ld_addr = la; sb_if.dm_ready = rdy; Reset = rst;
      req  = sv && (op != 2'b00);
      mis  = req && is_mis(op, a);
      ok   = req && !mis;
      full = (pend.size() == DEPTH);
      e_mis = mis;
      e_sst = ok && full;
      e_lst = lv && ld_hit(la);
      e_cnt = rst ? 0 : pend.size();
      wr_now = 1'b0;
      byp    = 1'b0;
      if (!rst && rdy) begin
         if (pend.size() != 0) begin
            exp_q.push_back(pend[0]);
            wr_now = 1'b1;
         end
`ifdef DM_STORE_BYPASS_EN
         else if (ok) begin
            exp_q.push_back(mk(op, a, d, pc));
            byp = 1'b1;
         end
`endif
      end
      chk_en = 1'b1;
      if (rst) begin
         pend.delete();
      end else begin
         if (wr_now) void'(pend.pop_front());
         if (ok && !full && !byp) pend.push_back(mk(op, a, d, pc));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, rdy, 1'b0);
   endtask

   // Monitor: compare predicted outputs and pop expected DM writes
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", 32'(count), 32'(e_cnt));
         chk("misalign", 32'(sb_if.misalign), 32'(e_mis));
         chk("st_stall", 32'(sb_if.st_stall), 32'(e_sst));
         chk("ld_stall", 32'(sb_if.ld_stall), 32'(e_lst));
         if (sb_if.m_data_byteen != 4'b0000) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write t=%0t got addr=%h be=%b want no write",
                        $time, sb_if.m_data_addr, sb_if.m_data_byteen);
            end else begin
               mw = exp_q.pop_front();
               chk("wr_addr", sb_if.m_data_addr, mw.addr);
               chk("wr_data", sb_if.m_data_wdata, mw.data);
               chk("wr_byteen", 32'(sb_if.m_data_byteen), 32'(mw.be));
               chk("wr_pc", sb_if.m_inst_addr, mw.pc);
            end
         end else begin
            chk("idle_addr", sb_if.m_data_addr, 32'h0);
            chk("idle_wdata", sb_if.m_data_wdata, 32'h0);
            chk("idle_pc", sb_if.m_inst_addr, 32'h0);
            if (exp_q.size() != 0) begin
               mw = exp_q.pop_front();
               total++;
               bad++;
               $display("FAIL missing_write t=%0t got byteen=0000 want addr=%h be=%b",
                        $time, mw.addr, mw.be);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_la;
      sb_if.st_valid = 1'b0; sb_if.st_op = 2'b00; sb_if.st_addr = '0; sb_if.st_data = '0;
      sb_if.st_pc = '0; sb_if.ld_valid = 1'b0; sb_if.ld_addr = '0; sb_if.dm_ready = 1'b0;
      Reset = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);

      // SB lane 3, then SH upper half, then misaligned SW
      step(1'b1, 2'b01, 32'h13, 32'hAB, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0);
      idle(1'b1, 2);
      step(1'b1, 2'b10, 32'h02, 32'h1234, 32'h404, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 2'b11, 32'h06, 32'hDEADBEEF, 32'h408, 1'b0, 32'h0, 1'b1, 1'b0);
      idle(1'b1, 2);

      // Fill to DEPTH with DM busy, fifth store stalls, then drain in order
      for (int k = 0; k < 5; k++)
         step(1'b1, 2'b11, 32'(4 * k), 32'h1000 + 32'(k), 32'h500 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0);
      idle(1'b1, 5);

      // Load hazard on a pending word
      step(1'b1, 2'b11, 32'h100, 32'hCAFE0000, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h102, 1'b1, 1'b0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h102, 1'b1, 1'b0);

      // Reset mid-drain discards the remaining entries
      for (int k = 0; k < 3; k++)
         step(1'b1, 2'b11, 32'h200 + 32'(4 * k), 32'h2000 + 32'(k), 32'h700, 1'b0, 32'h0, 1'b0, 1'b0);
      idle(1'b1, 1);
      step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h204, 1'b1, 1'b1);
      idle(1'b1, 4);

      // Back-to-back stores wrap the pointers
      for (int k = 0; k < 10; k++)
         step(1'b1, 2'b11, 32'h300 + 32'(4 * k), 32'h3000 + 32'(k), 32'h800 + 32'(4 * k),
              1'b0, 32'h0, 1'b1, 1'b0);
      idle(1'b1, 3);

      // Random traffic over a small address window so hazards and fills occur
      for (int k = 0; k < 3000; k++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = 32'h40 + 32'($urandom_range(0, 31));
         r_la = 32'h40 + 32'($urandom_range(0, 31));
         step(1'($urandom_range(0, 3) != 0), r_op, r_a, $urandom, $urandom,
              1'($urandom_range(0, 1)), r_la, 1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 199) == 0));
      end
      idle(1'b1, DEPTH + 2);

      chk_en = 1'b0;
      @(negedge clk);
      chk("leftover_writes", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
